// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared definitions for the fully-connected output stage:
//            controller state encoding and signed score limits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } fc_state_t;

  // Default score width of the final layer and its saturation limits.
  localparam int FC_OUT_W  = 16;
  localparam int SCORE_MAX = (2 ** (FC_OUT_W - 1)) - 1;
  localparam int SCORE_MIN = -(2 ** (FC_OUT_W - 1));

  // Width-generic limits so hidden layers with other score widths can reuse
  // the same saturation block.
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_shift_sat.sv
`default_nettype none
// ============================================================================
// Module   : fc_shift_sat
// Purpose  : Combinational rescale of a signed accumulator: arithmetic right
//            shift by FRAC_SHIFT (floor), then saturation to OUT_W bits.
// Ports    : i_acc   - signed accumulator value (ACC_W)
//            o_score - saturated signed score (OUT_W)
// Revision : 1.0 - initial release
// ============================================================================
module fc_shift_sat
  import fc_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_score
);

  localparam logic signed [ACC_W-1:0] c_acc_max = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] c_acc_min = ACC_W'(sat_min(OUT_W));

  logic signed [ACC_W-1:0] w_shifted;

  // Shift first, then clamp: the shift floors toward minus infinity, so a
  // small negative accumulator gives -1 rather than 0.
  always_comb begin
    w_shifted = i_acc >>> FRAC_SHIFT;
    if (w_shifted > c_acc_max) begin
      o_score = c_acc_max[OUT_W-1:0];
    end else if (w_shifted < c_acc_min) begin
      o_score = c_acc_min[OUT_W-1:0];
    end else begin
      o_score = w_shifted[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fc_score_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fc_score_accumulator
// Purpose  : Final FC layer output stage. Accumulates the signed product
//            stream per output neuron (bias folded in on the first product),
//            rescales/saturates each neuron to a score, stores all scores,
//            then streams them one per handshake and pulses Done.
// Ports    : FCO_CLOCK_50 / FCO_RESET_InHigh - clock, sync active-high reset
//            FCO_Start                        - begin image (IDLE only)
//            FCO_Prod_* / FCO_Bias_In         - product stream input
//            FCO_Score_*                      - score stream output
//            FCO_Done / FCO_Busy              - status
// Revision : 1.0 - initial release
// ============================================================================
module fc_score_accumulator
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int IN_W        = 16,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int FRAC_SHIFT  = 8
) (
  input  logic             FCO_CLOCK_50,
  input  logic             FCO_RESET_InHigh,
  input  logic             FCO_Start,
  input  logic [IN_W-1:0]  FCO_Prod_In,
  input  logic [IN_W-1:0]  FCO_Bias_In,
  input  logic             FCO_Prod_Valid,
  input  logic             FCO_Prod_Last,
  output logic             FCO_Prod_Ready,
  output logic [OUT_W-1:0] FCO_Score_Out,
  output logic [3:0]       FCO_Score_Idx,
  output logic             FCO_Score_Valid,
  output logic             FCO_Score_Last,
  input  logic             FCO_Score_Ready,
  output logic             FCO_Done,
  output logic             FCO_Busy
);

  localparam logic [3:0] c_last_idx = 4'(NUM_CLASSES - 1);

  fc_state_t               state_q, state_d;
  logic [3:0]              class_q, class_d;
  logic [3:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic signed [OUT_W-1:0] score_q [NUM_CLASSES];
  logic signed [OUT_W-1:0] score_d [NUM_CLASSES];

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [OUT_W-1:0] w_sat_score;

  assign w_prod_ext = {{(ACC_W-IN_W){FCO_Prod_In[IN_W-1]}}, FCO_Prod_In};
  assign w_bias_ext = {{(ACC_W-IN_W){FCO_Bias_In[IN_W-1]}}, FCO_Bias_In};

  // Accumulator value including the current product; the bias is aligned to
  // the product's fixed-point scale so the final shift treats both alike.
  assign w_acc_next = first_q ? ((w_bias_ext <<< FRAC_SHIFT) + w_prod_ext)
                              : (acc_q + w_prod_ext);

  fc_shift_sat #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_shift_sat (
    .i_acc   (w_acc_next),
    .o_score (w_sat_score)
  );

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    first_d = first_q;
    score_d = score_q;

    case (state_q)
      ST_IDLE: begin
        if (FCO_Start) begin
          state_d = ST_ACCUM;
          class_d = '0;
          first_d = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (FCO_Prod_Valid) begin
          acc_d   = w_acc_next;
          first_d = 1'b0;
          if (FCO_Prod_Last) begin
            score_d[class_q] = w_sat_score;
            first_d          = 1'b1;
            class_d          = class_q + 4'd1;
            if (class_q == c_last_idx) begin
              state_d = ST_STREAM;
              idx_d   = '0;
            end
          end
        end
      end
      ST_STREAM: begin
        if (FCO_Score_Ready) begin
          if (idx_q == c_last_idx) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge FCO_CLOCK_50) begin
    if (FCO_RESET_InHigh) begin
      state_q <= ST_IDLE;
      class_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      first_q <= 1'b1;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      score_q <= score_d;
    end
  end

  // Score outputs are gated to zero outside STREAM so the bus is quiet when
  // no score is being offered.
  assign FCO_Prod_Ready  = (state_q == ST_ACCUM);
  assign FCO_Score_Valid = (state_q == ST_STREAM);
  assign FCO_Score_Out   = FCO_Score_Valid ? score_q[idx_q] : '0;
  assign FCO_Score_Idx   = FCO_Score_Valid ? idx_q : '0;
  assign FCO_Score_Last  = FCO_Score_Valid && (idx_q == c_last_idx);
  assign FCO_Done        = (state_q == ST_DONE);
  assign FCO_Busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fc_score_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_score_accumulator
// Purpose  : Self-checking bench for fc_score_accumulator. Expected scores are
//            computed from the driven stimulus and queued; they are popped and
//            compared as the DUT hands each score over.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_score_accumulator;

  localparam int NUM_CLASSES = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] prod_in;
  logic [15:0] bias_in;
  logic        prod_valid;
  logic        prod_last;
  logic        prod_ready;
  logic [15:0] score_out;
  logic [3:0]  score_idx;
  logic        score_valid;
  logic        score_last;
  logic        score_ready;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  fc_score_accumulator #(
    .NUM_CLASSES (NUM_CLASSES),
    .IN_W        (16),
    .ACC_W       (32),
    .OUT_W       (16),
    .FRAC_SHIFT  (8)
  ) dut (
    .FCO_CLOCK_50     (clk),
    .FCO_RESET_InHigh (rst),
    .FCO_Start        (start),
    .FCO_Prod_In      (prod_in),
    .FCO_Bias_In      (bias_in),
    .FCO_Prod_Valid   (prod_valid),
    .FCO_Prod_Last    (prod_last),
    .FCO_Prod_Ready   (prod_ready),
    .FCO_Score_Out    (score_out),
    .FCO_Score_Idx    (score_idx),
    .FCO_Score_Valid  (score_valid),
    .FCO_Score_Last   (score_last),
    .FCO_Score_Ready  (score_ready),
    .FCO_Done         (done),
    .FCO_Busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bias scaled by 2^8, plus products, floor-shift, clamp.
  function automatic logic [15:0] model(input int bias, input int p_first,
                                        input int p_rest, input int count);
    longint acc;
    longint s;
    acc = longint'(bias) * 256 + longint'(p_first) + longint'(p_rest) * (count - 1);
    s   = acc >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_prod_ready"}, {31'b0, prod_ready}, 32'd0);
    chk({tag, "_score_out"}, {16'b0, score_out}, 32'd0);
    chk({tag, "_score_idx"}, {28'b0, score_idx}, 32'd0);
    chk({tag, "_score_valid"}, {31'b0, score_valid}, 32'd0);
    chk({tag, "_score_last"}, {31'b0, score_last}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_prod_ready", {31'b0, prod_ready}, 32'd1);
  endtask

  task automatic send_neuron(input int bias, input int p_first, input int p_rest,
                             input int count);
    sb.push_back(model(bias, p_first, p_rest, count));
    chk("accum_prod_ready", {31'b0, prod_ready}, 32'd1);
    for (int k = 0; k < count; k++) begin
      bias_in    = 16'(bias);
      prod_in    = (k == 0) ? 16'(p_first) : 16'(p_rest);
      prod_valid = 1'b1;
      prod_last  = (k == count - 1);
      @(posedge clk); #1;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Consume the score stream. A stall of stall_cycles is inserted when the
  // offered index equals stall_idx; during the stall Start and Prod_Valid are
  // driven and must be ignored. stop_at >= 0 returns with that index offered.
  task automatic drain(input int stall_idx, input int stall_cycles, input int stop_at);
    int          stalls  = stall_cycles;
    int          exp_idx = 0;
    int          budget  = 200;
    logic [15:0] held_out;
    logic [3:0]  held_idx;
    logic [15:0] e;
    while (exp_idx < NUM_CLASSES && budget > 0) begin
      budget--;
      if (exp_idx == stop_at) return;
      if (exp_idx == stall_idx && stalls > 0) begin
        score_ready = 1'b0;
        if (stalls == stall_cycles) begin
          held_out = score_out;
          held_idx = score_idx;
        end else begin
          chk("stall_hold_out", {16'b0, score_out}, {16'b0, held_out});
          chk("stall_hold_idx", {28'b0, score_idx}, {28'b0, held_idx});
        end
        chk("stall_valid", {31'b0, score_valid}, 32'd1);
        chk("stream_prod_ready", {31'b0, prod_ready}, 32'd0);
        start      = 1'b1;
        prod_valid = 1'b1;
        prod_last  = 1'b1;
        prod_in    = 16'h7FFF;
        stalls--;
        @(posedge clk); #1;
      end else begin
        start       = 1'b0;
        prod_valid  = 1'b0;
        prod_last   = 1'b0;
        score_ready = 1'b1;
        e = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        chk("score_valid", {31'b0, score_valid}, 32'd1);
        chk("score_idx", {28'b0, score_idx}, 32'(exp_idx));
        chk("score_out", {16'b0, score_out}, {16'b0, e});
        chk("score_last", {31'b0, score_last}, {31'b0, exp_idx == NUM_CLASSES - 1});
        chk("stream_done_low", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        exp_idx++;
      end
    end
    score_ready = 1'b0;
    start       = 1'b0;
    prod_valid  = 1'b0;
    prod_last   = 1'b0;
    chk("drain_budget", 32'(exp_idx), 32'(NUM_CLASSES));
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd1);
    chk("done_valid_low", {31'b0, score_valid}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    prod_in     = '0;
    bias_in     = '0;
    prod_valid  = 1'b0;
    prod_last   = 1'b0;
    score_ready = 1'b0;

    // Reset, with Start coinciding on the last reset edge: reset wins.
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check_zero("reset");

    // Basic image: every neuron bias 2, products 256 then 512 -> score 5.
    do_start();
    for (int i = 0; i < NUM_CLASSES; i++) send_neuron(2, 256, 512, 2);
    chk("first_valid_latency", {31'b0, score_valid}, 32'd1);
    drain(-1, 0, -1);

    // Products offered in IDLE are not accepted.
    prod_valid = 1'b1;
    prod_last  = 1'b1;
    prod_in    = 16'd1000;
    bias_in    = 16'd1000;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_prod_ready", {31'b0, prod_ready}, 32'd0);
      chk("idle_busy_stays", {31'b0, busy}, 32'd0);
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;

    // Saturation / floor image with a Start pulse during ACCUM and
    // backpressure at index 4.
    do_start();
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (i == 3)      send_neuron(0, 32767, 32767, 512);
      else if (i == 5) send_neuron(0, -32768, -32768, 300);
      else if (i == 7) send_neuron(0, -1, -1, 1);
      else             send_neuron(1, 100, 100, 1);
      if (i == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accum_start_ignored_busy", {31'b0, busy}, 32'd1);
        chk("accum_start_ignored_ready", {31'b0, prod_ready}, 32'd1);
      end
    end
    drain(4, 3, -1);

    // Reset in ACCUM while neuron 6 is being accumulated.
    do_start();
    for (int i = 0; i < 6; i++) send_neuron(3, 700, -50, 3);
    prod_valid = 1'b1;
    prod_in    = 16'd1234;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    prod_valid = 1'b0;
    check_zero("reset_accum");
    sb.delete();

    // Fresh image with mixed signs and lengths.
    do_start();
    for (int i = 0; i < NUM_CLASSES; i++) send_neuron(i - 5, 37 * i - 200, 11 * i - 60, 1 + (i % 3));
    drain(-1, 0, -1);

    // Reset in STREAM with index 2 offered.
    do_start();
    for (int i = 0; i < NUM_CLASSES; i++) send_neuron(-1, -300, 0, 1);
    drain(-1, 0, 2);
    chk("pre_reset_idx", {28'b0, score_idx}, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    score_ready = 1'b0;
    check_zero("reset_stream");
    sb.delete();

    // Fresh image after the stream reset.
    do_start();
    for (int i = 0; i < NUM_CLASSES; i++) send_neuron(2, 256, 512, 2);
    drain(-1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_score_accumulator.md
Name: fc_score_accumulator

Overview:
Output stage of the final fully-connected layer. It accumulates the signed MAC product stream for each of the NUM_CLASSES output neurons, adds the per-neuron bias, rescales and saturates each result to a 16-bit score, and stores all scores. It then streams the scores one per handshake to the argmax stage and pulses a done strobe that drives that stage's enable.

Parameters:
NUM_CLASSES, 10, number of output neurons/classes (2..16)
IN_W, 16, signed product and bias width
ACC_W, 32, signed accumulator width
OUT_W, 16, signed score width
FRAC_SHIFT, 8, arithmetic right shift applied to the final accumulator

Ports:
FCO_CLOCK_50  in  1  clock; all logic on the rising edge
FCO_RESET_InHigh  in  1  synchronous, active-high reset
FCO_Start  in  1  begin a new image; honoured only in IDLE
FCO_Prod_In  in  IN_W  signed product, current neuron
FCO_Bias_In  in  IN_W  signed bias, sampled with the first product of each neuron
FCO_Prod_Valid  in  1  product valid
FCO_Prod_Last  in  1  last product of current neuron; qualified by Valid
FCO_Prod_Ready  out  1  high only in ACCUM
FCO_Score_Out  out  OUT_W  signed score at FCO_Score_Idx
FCO_Score_Idx  out  4  class index 0..NUM_CLASSES-1
FCO_Score_Valid  out  1  score valid (STREAM)
FCO_Score_Last  out  1  Valid and Idx==NUM_CLASSES-1
FCO_Score_Ready  in  1  downstream accepts
FCO_Done  out  1  one-cycle pulse after last score accepted
FCO_Busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, FCO_RESET_InHigh=1 at a clock edge) applies from any state, including mid-accumulate or mid-stream. It forces state=IDLE, class counter=0, stream index=0, acc=0, first-flag=1, and every score register=0. All outputs go to 0: Prod_Ready, Score_Out, Score_Idx, Score_Valid, Score_Last, Done, Busy.
- Registered state machine with states IDLE, ACCUM, STREAM, DONE.
- IDLE: with Start=1, go to ACCUM, set class counter=0, set first-flag=1. Products are ignored in IDLE.
- ACCUM: Prod_Ready=1. A transfer is Valid&&Ready.
  - On a transfer with first-flag=1: acc <= (sext(Bias)<<<FRAC_SHIFT) + sext(Prod), and first-flag is cleared.
  - On a transfer with first-flag=0: acc <= acc + sext(Prod).
  - Acc overflow wraps modulo 2^ACC_W (not detected). Sizing ACC_W is the integrator's responsibility.
- Neuron end (transfer with Last=1): compute the neuron result with shift-then-saturate.
  - acc_next is the acc value including this product; a single-product neuron is legal.
  - The score is acc_next>>>FRAC_SHIFT (floor), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], written to score[class].
  - Set first-flag=1 and increment class.
  - If class was NUM_CLASSES-1, go to STREAM with index=0.
- STREAM: Valid=1, Score_Out=score[idx], Idx=idx.
  - On Ready=1, increment idx.
  - On Ready=1 at idx=NUM_CLASSES-1, go to DONE.
  - Outputs are held stable while Ready=0.
  - Output latency: first score valid on the cycle after the last product's transfer.
- DONE: Done=1 for exactly one cycle, then IDLE. Stored scores are retained until the next accumulate or a reset.
- Start is ignored in ACCUM, STREAM and DONE.
- Start=1 in IDLE on the same edge as reset: reset wins.
- Valid with Last=1 on the same cycle is the final product; there is no separate end beat.
- Minimum image time: P+NUM_CLASSES+2 cycles (P = products) with no stalls.

Decomposition:
- Shared package fc_pkg: the state encoding (IDLE=0, ACCUM=1, STREAM=2, DONE=3) and constants SCORE_MAX/SCORE_MIN derived from OUT_W.
- One combinational sub-module fc_shift_sat (parameters ACC_W, OUT_W, FRAC_SHIFT): arithmetic shift plus saturation, reusable by the hidden layers.

Test Plan:
- Basic accumulate and stream: Start; all neurons bias=2, products 256, 512 (last). Required: each score=(512+256+512)>>8=5; Idx 0..9 on consecutive cycles with Ready=1; Last at Idx 9; Done one cycle after.
- Positive saturation: neuron 3 bias=0, 512 products of 32767. Required: score[3]=32767, other neurons as driven.
- Negative saturation and floor: one neuron 300 products of -32768 gives -32768. Another neuron bias=0 with single product -1 gives score -1 (floor, not 0).
- Backpressure: Ready=0 for 3 cycles while Idx=4. Required: Score_Out/Idx/Valid held constant; Idx 5 follows the first Ready=1; Done only after Idx 9 is accepted.
- Ignored stimuli: Start pulsed during ACCUM and STREAM, and Prod_Valid driven in IDLE and STREAM. Required: no state change, scores unaffected, Prod_Ready=0 outside ACCUM.
- Reset mid-operation: assert reset at class 6 of ACCUM, and separately at Idx 2 of STREAM. Required: next cycle all outputs 0 and state IDLE; a fresh Start produces correct scores.
